// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the word-indexed PC, addresses the ROM and fills the IF/ID register.
// Handles stalls, branch/jump redirects with NOP bubbles, and halts when the PC leaves the ROM.
module fetch_sequencer #(
   parameter int unsigned P_SIZE        = 32,
   parameter int unsigned I_SIZE        = 32,
   parameter int unsigned DEPTH         = 32,
   parameter int unsigned FLUSH_BUBBLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en,
   input  logic              stall_i,
   input  logic              redirect_vld_i,
   input  logic [P_SIZE-1:0] redirect_pc_i,
   input  logic [I_SIZE-1:0] imem_instr_i,
   output logic [P_SIZE-1:0] pc_o,
   output logic              ifid_vld_o,
   output logic [I_SIZE-1:0] ifid_instr_o,
   output logic [P_SIZE-1:0] ifid_pc_o,
   output logic              halt_o,
   output logic              err_o
);

   // Extra bit keeps the range check exact even when DEPTH == 2**P_SIZE.
   localparam logic [P_SIZE:0]   DEPTH_EXT   = (P_SIZE + 1)'(DEPTH);
   localparam logic [P_SIZE-1:0] LAST_PC     = P_SIZE'(DEPTH - 1);
   localparam logic [1:0]        BUBBLE_INIT = 2'(FLUSH_BUBBLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_STALL,
      S_FLUSH,
      S_HALT
   } state_t;

   state_t              state, state_nxt;
   logic [P_SIZE-1:0]   pc, pc_nxt;
   logic                vld, vld_nxt;
   logic [I_SIZE-1:0]   instr, instr_nxt;
   logic [P_SIZE-1:0]   ipc, ipc_nxt;
   logic [1:0]          cnt, cnt_nxt;
   logic                err, err_nxt;
   logic                target_ok;
   logic                at_end;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         pc    <= '0;
         vld   <= 1'b0;
         instr <= '0;
         ipc   <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         vld   <= vld_nxt;
         instr <= instr_nxt;
         ipc   <= ipc_nxt;
         cnt   <= cnt_nxt;
         err   <= err_nxt;
      end
   end

   assign target_ok = {1'b0, redirect_pc_i} < DEPTH_EXT;
   assign at_end    = (pc == LAST_PC);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      vld_nxt   = vld;
      instr_nxt = instr;
      ipc_nxt   = ipc;
      cnt_nxt   = cnt;
      err_nxt   = err;

      case (state)
         S_IDLE: begin
            vld_nxt   = 1'b0;
            instr_nxt = '0;
            ipc_nxt   = '0;
            if (fetch_en) state_nxt = S_RUN;
         end

         S_HALT: begin
            vld_nxt   = 1'b0;
            instr_nxt = '0;
            ipc_nxt   = '0;
         end

         default: begin
            if (redirect_vld_i) begin
               // The redirect edge itself is the first bubble slot.
               vld_nxt   = 1'b0;
               instr_nxt = '0;
               ipc_nxt   = '0;
               if (target_ok) begin
                  pc_nxt    = redirect_pc_i;
                  cnt_nxt   = BUBBLE_INIT;
                  state_nxt = (FLUSH_BUBBLES > 1) ? S_FLUSH : S_RUN;
               end else begin
                  state_nxt = S_HALT;
                  err_nxt   = 1'b1;
               end
            end else if (state == S_FLUSH) begin
               vld_nxt   = 1'b0;
               instr_nxt = '0;
               ipc_nxt   = '0;
               cnt_nxt   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
               if (cnt <= 2'd1) state_nxt = S_RUN;
            end else if (stall_i) begin
               state_nxt = S_STALL;
            end else begin
               vld_nxt   = 1'b1;
               instr_nxt = imem_instr_i;
               ipc_nxt   = pc;
               if (at_end) begin
                  state_nxt = S_HALT;
               end else begin
                  pc_nxt    = pc + P_SIZE'(1);
                  state_nxt = S_RUN;
               end
            end
         end
      endcase
   end

   assign pc_o         = pc;
   assign ifid_vld_o   = vld;
   assign ifid_instr_o = instr;
   assign ifid_pc_o    = ipc;
   assign halt_o       = (state == S_HALT);
   assign err_o        = err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a spec-level model is compared every cycle, plus literal checks.
module tb_fetch_sequencer;

   localparam int unsigned DEPTH = 32;
   localparam int unsigned FB    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_en = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_vld_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic [31:0] imem_instr_i;
   logic [31:0] pc_o;
   logic        ifid_vld_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc_o;
   logic        halt_o;
   logic        err_o;

   logic [31:0] rom [DEPTH];

   int n_vec = 0;
   int n_bad = 0;

   fetch_sequencer #(
      .P_SIZE(32),
      .I_SIZE(32),
      .DEPTH(DEPTH),
      .FLUSH_BUBBLES(FB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fetch_en(fetch_en),
      .stall_i(stall_i),
      .redirect_vld_i(redirect_vld_i),
      .redirect_pc_i(redirect_pc_i),
      .imem_instr_i(imem_instr_i),
      .pc_o(pc_o),
      .ifid_vld_o(ifid_vld_o),
      .ifid_instr_o(ifid_instr_o),
      .ifid_pc_o(ifid_pc_o),
      .halt_o(halt_o),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   assign imem_instr_i = (pc_o < DEPTH) ? rom[pc_o[4:0]] : '0;

   // Spec-level model: a started/halted flag, a count of bubble slots still owed, and the PC.
   bit          m_started, m_halted, m_err, m_vld;
   int          m_bub;
   logic [31:0] m_pc, m_instr, m_ipc;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_started = 0; m_halted = 0; m_err = 0; m_vld = 0;
         m_bub = 0; m_pc = 0; m_instr = 0; m_ipc = 0;
      end else if (!m_started) begin
         if (fetch_en) m_started = 1;
      end else if (m_halted) begin
         m_vld = 0; m_instr = 0;
      end else if (redirect_vld_i) begin
         m_vld = 0; m_instr = 0;
         if (redirect_pc_i < DEPTH) begin
            m_pc  = redirect_pc_i;
            m_bub = FB - 1;
         end else begin
            m_halted = 1; m_err = 1;
         end
      end else if (m_bub > 0) begin
         m_vld = 0; m_instr = 0; m_bub--;
      end else if (!stall_i) begin
         m_vld = 1; m_instr = rom[m_pc[4:0]]; m_ipc = m_pc;
         if (m_pc == DEPTH - 1) m_halted = 1;
         else m_pc++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_pc", pc_o, m_pc);
      check("model_vld", 32'(ifid_vld_o), 32'(m_vld));
      check("model_instr", ifid_instr_o, m_instr);
      if (m_vld) check("model_ifid_pc", ifid_pc_o, m_ipc);
      check("model_halt", 32'(halt_o), 32'(m_halted));
      check("model_err", 32'(err_o), 32'(m_err));
   end

   task automatic tick(input logic fe, input logic st, input logic rv, input logic [31:0] rt);
      fetch_en = fe; stall_i = st; redirect_vld_i = rv; redirect_pc_i = rt;
      @(negedge clk);
   endtask

   task automatic mid_reset();
      fetch_en = 0; stall_i = 0; redirect_vld_i = 0; redirect_pc_i = '0;
      #2 rst = 1'b0;
      #1;
      check("rst_pc", pc_o, 32'd0);
      check("rst_vld", 32'(ifid_vld_o), 32'd0);
      check("rst_instr", ifid_instr_o, 32'd0);
      check("rst_ifid_pc", ifid_pc_o, 32'd0);
      check("rst_halt", 32'(halt_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 32'hC0DE_0000 + 32'(i) * 32'd17;

      @(negedge clk);
      check("reset_pc", pc_o, 32'd0);
      check("reset_vld", 32'(ifid_vld_o), 32'd0);
      check("reset_halt", 32'(halt_o), 32'd0);
      rst = 1'b1;

      // Idle without fetch_en: nothing happens
      tick(0, 0, 0, 0);
      check("idle_pc", pc_o, 32'd0);
      tick(1, 0, 0, 0);
      check("start_vld", 32'(ifid_vld_o), 32'd0);

      // T1: sequential fetch
      for (int k = 0; k < 5; k++) begin
         tick(0, 0, 0, 0);
         check("t1_ifid_pc", ifid_pc_o, 32'(k));
         check("t1_vld", 32'(ifid_vld_o), 32'd1);
      end
      check("t1_instr4", ifid_instr_o, 32'hC0DE_0044);
      check("t1_pc", pc_o, 32'd5);

      // T2: stall at pc 5
      for (int k = 0; k < 3; k++) begin
         tick(0, 1, 0, 0);
         check("t2_pc_hold", pc_o, 32'd5);
         check("t2_ifid_hold", ifid_pc_o, 32'd4);
      end
      tick(0, 0, 0, 0);
      check("t2_resume", ifid_pc_o, 32'd5);
      check("t2_pc", pc_o, 32'd6);
      repeat (3) tick(0, 0, 0, 0);

      // T3: redirect to 13 at pc 9, stall ignored during the flush slot
      check("t3_pre_pc", pc_o, 32'd9);
      tick(0, 0, 1, 13);
      check("t3_bub1", 32'(ifid_vld_o), 32'd0);
      tick(0, 1, 0, 0);
      check("t3_bub2", 32'(ifid_vld_o), 32'd0);
      check("t3_pc", pc_o, 32'd13);
      tick(0, 0, 0, 0);
      check("t3_ifid_pc", ifid_pc_o, 32'd13);
      check("t3_instr", ifid_instr_o, 32'hC0DE_00DD);

      // T4: redirect beats stall, also from the STALL state
      tick(0, 1, 1, 20);
      check("t4_pc", pc_o, 32'd20);
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      check("t4_ifid_pc", ifid_pc_o, 32'd20);
      tick(0, 1, 0, 0);
      tick(0, 1, 1, 28);
      check("t4_stall_redirect", pc_o, 32'd28);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      check("t4_ifid_pc28", ifid_pc_o, 32'd28);

      // T5: run off the end of the ROM
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      check("t5_last_pc", ifid_pc_o, 32'd31);
      check("t5_last_instr", ifid_instr_o, 32'hC0DE_020F);
      check("t5_halt", 32'(halt_o), 32'd1);
      tick(0, 0, 1, 3);
      check("t5_pc_held", pc_o, 32'd31);
      check("t5_nop", 32'(ifid_vld_o), 32'd0);
      check("t5_no_err", 32'(err_o), 32'd0);
      tick(1, 1, 0, 0);

      // Redirect to the last legal entry
      mid_reset();
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 1, 31);
      check("edge_pc31", pc_o, 32'd31);
      tick(0, 0, 0, 0);
      tick(0, 0, 0, 0);
      check("edge_halt", 32'(halt_o), 32'd1);
      check("edge_err", 32'(err_o), 32'd0);

      // T6: out-of-range redirect, sticky error
      mid_reset();
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
      tick(0, 0, 1, 40);
      check("t6_halt", 32'(halt_o), 32'd1);
      check("t6_err", 32'(err_o), 32'd1);
      tick(0, 0, 1, 5);
      check("t6_err_sticky", 32'(err_o), 32'd1);

      // Boundary target equal to DEPTH, taken from STALL
      mid_reset();
      tick(1, 1, 0, 0);
      tick(0, 1, 0, 0);
      tick(0, 1, 1, 32);
      check("oob32_err", 32'(err_o), 32'd1);

      // Full-width target with only a high bit set
      mid_reset();
      tick(1, 0, 0, 0);
      tick(0, 0, 1, 32'h8000_0005);
      check("wide_err", 32'(err_o), 32'd1);

      mid_reset();
      tick(0, 0, 0, 0);
      check("final_idle_pc", pc_o, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
